// File: rtl/counter_sequencer.sv
// counter_sequencer: start/stop/hold/reload control around a prescaled
// N-bit up-count with a programmable terminal value. One-shot or periodic,
// with a registered one-cycle done pulse at each terminal count.
module counter_sequencer #(
    parameter int N        = 4,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         hold,
    input  logic         mode,
    input  logic [N-1:0] limit,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done
);
    // Prescale counter is at least one bit wide so PRESCALE=1 still has a
    // legal register; with PRESCALE=1 it sits at 0 == PS_MAX forever.
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PS_MAX = PSW'(PRESCALE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   q_q, q_d;
    logic [PSW-1:0] ps_q, ps_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic [N-1:0]   limit_q, limit_d;
    logic           mode_q, mode_d;
    logic           active;

    // Any state other than RUN/HOLD (including the unused code) acts as IDLE.
    assign active = (state_q == S_RUN) || (state_q == S_HOLD);

    // Next-state: stop beats start beats hold beats the prescale tick.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        ps_d    = ps_q;
        done_d  = 1'b0;
        limit_d = limit_q;
        mode_d  = mode_q;
        if (stop) begin
            state_d = S_IDLE;
            q_d     = '0;
            ps_d    = '0;
        end else if (start) begin
            limit_d = limit;
            mode_d  = mode;
            q_d     = '0;
            ps_d    = '0;
            state_d = S_RUN;
        end else if (active) begin
            if (hold) begin
                // Frozen: q and ps keep their values for this edge.
                state_d = S_HOLD;
            end else begin
                // Leaving HOLD counts on the same edge hold is seen low, so
                // a hold of H cycles shifts every later event by exactly H.
                state_d = S_RUN;
                if (ps_q != PS_MAX) begin
                    ps_d = ps_q + PSW'(1);
                end else begin
                    ps_d = '0;
                    if (q_q != limit_q) begin
                        q_d = q_q + N'(1);
                    end else begin
                        q_d    = '0;
                        done_d = 1'b1;
                        if (!mode_q)
                            state_d = S_IDLE;
                    end
                end
            end
        end else begin
            state_d = S_IDLE;
            q_d     = '0;
            ps_d    = '0;
        end
        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            ps_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            limit_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            ps_q    <= ps_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
        end
    end

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
